fifo_uart_tx: RTL and testbench

Byte FIFO plus UART transmitter forming the stage directly downstream of the CRC/FIFO-write stage. It accepts bytes on a single-cycle write strobe, and exposes `fifo_busy` so the producer only writes when space exists. It drains stored bytes onto a serial line as 8N1 frames (LSB first). Sticky overflow flag and occupancy count are provided for debug LEDs.

---
 rtl/fifo_uart_tx.sv | 153 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first).
// The FIFO pops only when the transmitter is idle and enabled.
module fifo_uart_tx #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      din,
  input  logic            fifo_we,
  output logic            fifo_busy,
  input  logic            tx_enable,
  output logic            tx,
  output logic            tx_busy,
  output logic [ADDR_W:0] count,
  output logic            overflow
);

  localparam int BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]        bidx_q, bidx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              tx_q, tx_d;

  logic full;
  logic accept;
  logic pop;
  logic bitEnd;
  logic [2:0] bidxNext;

  assign full     = (count_q == FULL_CNT);
  assign accept   = fifo_we && !full;
  assign pop      = (state_q == IDLE) && tx_enable && (count_q != '0);
  assign bitEnd   = (bcnt_q == BCNT_MAX);
  assign bidxNext = bidx_q + 3'd1;

  // A write rejected while full stays rejected even if a pop frees a slot on the same edge.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (fifo_we & full);
    if (accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = START;
          tx_d    = 1'b0;
          bcnt_d  = '0;
          shreg_d = mem_q[rd_ptr_q];
        end
      end
      START: begin
        if (bitEnd) begin
          state_d = DATA;
          bidx_d  = 3'd0;
          tx_d    = shreg_q[0];
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bidx_d = bidxNext;
            tx_d   = shreg_q[bidxNext];
          end
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: begin
        tx_d = 1'b1;
        if (bitEnd) begin
          state_d = IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
    end
  end

  assign fifo_busy = full;
  assign tx        = tx_q;
  assign tx_busy   = (state_q != IDLE);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a UART frame monitor checks every serial cycle
// against a queue of bytes pushed when writes are driven.
module tb_fifo_uart_tx;

  localparam int DEPTH = 16;
  localparam int ADDR_W = 4;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic fifo_we = 1'b0;
  logic tx_enable = 1'b0;
  logic fifo_busy, tx, tx_busy, overflow;
  logic [ADDR_W:0] count;

  fifo_uart_tx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .din(din), .fifo_we(fifo_we), .fifo_busy(fifo_busy),
    .tx_enable(tx_enable), .tx(tx), .tx_busy(tx_busy), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] sbq[$];
  int fallTimes[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame monitor: compares tx against the expected 8N1 waveform every cycle.
  bit monActive = 0;
  int monCnt = 0;
  bit monBad = 0;
  logic [7:0] monExp = 8'h00;
  logic [7:0] monGot = 8'h00;

  always @(negedge clk) begin
    int k;
    logic expBit;
    if (reset) begin
      monActive = 0;
    end else if (!monActive) begin
      if (tx === 1'b0) begin
        monActive = 1;
        monCnt = 0;
        monBad = 0;
        monGot = 8'h00;
        fallTimes.push_back(cyc);
        if (sbq.size() == 0) begin
          checkOutput("unexpected_frame", 32'(sbq.size() != 0), 32'd1);
          monExp = 8'h00;
        end else begin
          monExp = sbq[0];
        end
      end
    end else begin
      monCnt++;
      k = monCnt / CPB;
      if (k == 0) expBit = 1'b0;
      else if (k <= 8) expBit = monExp[k-1];
      else expBit = 1'b1;
      if (tx !== expBit) monBad = 1;
      if ((monCnt % CPB) == 1 && k >= 1 && k <= 8) monGot[k-1] = tx;
      if (monCnt == 10 * CPB - 1) begin
        checkOutput("frame_byte", 32'(monGot), 32'(monExp));
        checkOutput("frame_shape", 32'(monBad), 32'd0);
        if (sbq.size() > 0) void'(sbq.pop_front());
        monActive = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] d, input logic en);
    fifo_we = we;
    din = d;
    tx_enable = en;
    @(posedge clk);
    #1;
    fifo_we = 1'b0;
  endtask

  task automatic writeByte(input logic [7:0] d, input logic en);
    sbq.push_back(d);
    applyStimulus(1'b1, d, en);
  endtask

  task automatic doReset();
    reset = 1'b1;
    sbq.delete();
    step(2);
    reset = 1'b0;
    fallTimes.delete();
  endtask

  task automatic waitIdle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      if (sbq.size() == 0 && !tx_busy && !monActive) begin
        done = 1;
        break;
      end
      step(1);
    end
    checkOutput("drain_done", 32'(done), 32'd1);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       en;
    logic       expAccept;
    logic [4:0] expCount;
    logic       expBusy;
    logic       expOvf;
  } vec_t;

  vec_t fillVec[17];

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 17; i++) begin
      fillVec[i].we = 1'b1;
      fillVec[i].d = 8'h30 + 8'(i * 7);
      fillVec[i].en = 1'b0;
      fillVec[i].expAccept = (i < DEPTH);
      fillVec[i].expCount = (i < DEPTH) ? 5'(i + 1) : 5'(DEPTH);
      fillVec[i].expBusy = (i >= DEPTH - 1);
      fillVec[i].expOvf = (i >= DEPTH);
    end

    // Reset values
    doReset();
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_fifo_busy", 32'(fifo_busy), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);

    // Single byte 0xA5
    writeByte(8'hA5, 1'b1);
    checkOutput("a5_count_after_write", 32'(count), 32'd1);
    checkOutput("a5_tx_before_pop", 32'(tx), 32'd1);
    step(1);
    checkOutput("a5_count_after_pop", 32'(count), 32'd0);
    checkOutput("a5_tx_start", 32'(tx), 32'd0);
    checkOutput("a5_tx_busy", 32'(tx_busy), 32'd1);
    waitIdle(200);

    // Three back-to-back frames
    fallTimes.delete();
    writeByte(8'h01, 1'b1);
    writeByte(8'h02, 1'b1);
    writeByte(8'h03, 1'b1);
    checkOutput("b2b_count_peak", 32'(count), 32'd2);
    waitIdle(400);
    checkOutput("b2b_frames", 32'(fallTimes.size()), 32'd3);
    if (fallTimes.size() == 3) begin
      checkOutput("b2b_period1", 32'(fallTimes[1] - fallTimes[0]), 32'(10 * CPB + 1));
      checkOutput("b2b_period2", 32'(fallTimes[2] - fallTimes[1]), 32'(10 * CPB + 1));
    end
    checkOutput("b2b_count_end", 32'(count), 32'd0);

    // Fill with tx disabled, 17th byte dropped
    for (int i = 0; i < 17; i++) begin
      if (fillVec[i].expAccept) sbq.push_back(fillVec[i].d);
      applyStimulus(fillVec[i].we, fillVec[i].d, fillVec[i].en);
      checkOutput($sformatf("fill%0d_count", i), 32'(count), 32'(fillVec[i].expCount));
      checkOutput($sformatf("fill%0d_busy", i), 32'(fifo_busy), 32'(fillVec[i].expBusy));
      checkOutput($sformatf("fill%0d_ovf", i), 32'(overflow), 32'(fillVec[i].expOvf));
    end
    checkOutput("fill_tx_idle", 32'(tx_busy), 32'd0);
    tx_enable = 1'b1;
    waitIdle(1500);
    checkOutput("fill_ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("fill_count_end", 32'(count), 32'd0);

    // Write on the pop edge of a full FIFO
    doReset();
    for (int i = 0; i < DEPTH; i++) writeByte(8'hC0 + 8'(i), 1'b0);
    checkOutput("full_busy", 32'(fifo_busy), 32'd1);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("popedge_count", 32'(count), 32'd15);
    checkOutput("popedge_ovf", 32'(overflow), 32'd1);
    checkOutput("popedge_busy", 32'(fifo_busy), 32'd0);
    writeByte(8'h77, 1'b1);
    checkOutput("refill_count", 32'(count), 32'd16);
    checkOutput("refill_busy", 32'(fifo_busy), 32'd1);
    waitIdle(1500);

    // Reset mid-DATA with bytes queued (overflow still set from above)
    for (int i = 0; i < 5; i++) writeByte(8'h51 + 8'(i), 1'b0);
    tx_enable = 1'b1;
    step(12);
    checkOutput("mid_busy_before", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    sbq.delete();
    step(1);
    checkOutput("mid_rst_tx", 32'(tx), 32'd1);
    checkOutput("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    fallTimes.delete();
    step(60);
    checkOutput("mid_no_frames", 32'(fallTimes.size()), 32'd0);
    checkOutput("mid_tx_busy_after", 32'(tx_busy), 32'd0);

    // Interleaved traffic wrapping the pointers
    for (int i = 0; i < 20; i++) begin
      writeByte(8'($urandom_range(0, 255)), 1'b1);
      if ((i % 4) == 3) step($urandom_range(30, 90));
    end
    waitIdle(2000);
    checkOutput("wrap_count_end", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
